// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode classes, link register.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_LINK   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Opcode classes understood by both the decoder and the next-PC logic.
  localparam logic [10:0] CODE_BRANCH      = 11'd31;
  localparam logic [10:0] CODE_BRANCH_LINK = 11'd32;

  // Register written with the return address on branch-and-link.
  localparam logic [3:0]  LINK_REG         = 4'd14;

  // Sign-extend a 24-bit word offset to the 32-bit PC width.
  function automatic logic [31:0] sext32(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next-PC and link-value arithmetic for the sequencer; all sums wrap modulo 2^32.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module next_pc_calc #(
  parameter logic [10:0] CODE_BRANCH      = pc_sequencer_pkg::CODE_BRANCH,
  parameter logic [10:0] CODE_BRANCH_LINK = pc_sequencer_pkg::CODE_BRANCH_LINK
) (
  input  logic [31:0] pc,
  input  logic [10:0] code,
  input  logic [23:0] offset,
  output logic [31:0] next_pc,
  output logic [31:0] link_value
);
  import pc_sequencer_pkg::*;

  // Branches take the signed offset, everything else falls through to pc+1.
  always_comb begin
    link_value = pc + 32'd1;
    if ((code == CODE_BRANCH) || (code == CODE_BRANCH_LINK)) begin
      next_pc = pc + sext32(offset);
    end else begin
      next_pc = link_value;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer owning the PC, branch redirect and r14 link write.
// Latency: one state per stage; instr_valid and exec_start are registered pulses.
// Backpressure: imem_req and rf_link_we are held until their ack; decode/exec wait on ctl_valid/exec_done.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC         = 32'd0,
  parameter logic [10:0] CODE_BRANCH      = pc_sequencer_pkg::CODE_BRANCH,
  parameter logic [10:0] CODE_BRANCH_LINK = pc_sequencer_pkg::CODE_BRANCH_LINK,
  parameter logic [3:0]  LINK_REG         = pc_sequencer_pkg::LINK_REG,
  parameter logic [7:0]  FETCH_TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ctl_valid,
  input  logic [10:0] ALUCtl_code,
  input  logic [23:0] br_address,
  output logic        exec_start,
  input  logic        exec_done,
  output logic        rf_link_we,
  output logic [3:0]  rf_link_addr,
  output logic [31:0] rf_link_data,
  input  logic        rf_link_ack,
  output logic [31:0] pc,
  output logic [31:0] retire_count,
  output logic        halted,
  output logic        fault
);
  import pc_sequencer_pkg::*;

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic [10:0] code_q;
  logic [23:0] offset_q;
  logic [31:0] next_pc;
  logic [31:0] link_value;
  logic        fetch_timeout;
  logic        is_link;
  logic        retire;

  next_pc_calc #(
    .CODE_BRANCH      (CODE_BRANCH),
    .CODE_BRANCH_LINK (CODE_BRANCH_LINK)
  ) u_next_pc (
    .pc         (pc),
    .code       (code_q),
    .offset     (offset_q),
    .next_pc    (next_pc),
    .link_value (link_value)
  );

  // An ack in the timeout cycle wins, so the timeout term excludes imem_ack.
  assign fetch_timeout = (state == ST_FETCH) && !imem_ack &&
                         (wait_cnt == (FETCH_TIMEOUT - 8'd1));
  assign is_link       = (code_q == CODE_BRANCH_LINK);
  assign retire        = ((state == ST_EXEC) && exec_done && !is_link) ||
                         ((state == ST_LINK) && rf_link_ack);

  // State register; reset drops every request output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_HALT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; run is only looked at in HALT and at retire.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_HALT:   if (run) next_state = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)           next_state = ST_DECODE;
        else if (fetch_timeout) next_state = ST_FAULT;
      end
      ST_DECODE: if (ctl_valid) next_state = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          if (is_link) next_state = ST_LINK;
          else         next_state = run ? ST_FETCH : ST_HALT;
        end
      end
      ST_LINK:   if (rf_link_ack) next_state = run ? ST_FETCH : ST_HALT;
      ST_FAULT:  next_state = ST_FAULT;
      default:   next_state = ST_FAULT;
    endcase
  end

  // Level outputs decoded straight from the state.
  always_comb begin
    imem_req   = (state == ST_FETCH);
    rf_link_we = (state == ST_LINK);
    halted     = (state == ST_HALT);
    fault      = (state == ST_FAULT);
  end

  assign imem_addr    = pc;
  assign rf_link_addr = LINK_REG;

  // Datapath: PC, captured instruction/control, pulses, retire and fetch-wait counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      retire_count <= 32'd0;
      instr        <= 32'd0;
      instr_valid  <= 1'b0;
      exec_start   <= 1'b0;
      code_q       <= 11'd0;
      offset_q     <= 24'd0;
      rf_link_data <= 32'd0;
      wait_cnt     <= 8'd0;
    end else begin
      instr_valid <= (state == ST_FETCH) && imem_ack;
      exec_start  <= (state == ST_DECODE) && ctl_valid;
      if ((state == ST_FETCH) && imem_ack) begin
        instr <= imem_rdata;
      end
      if ((state == ST_DECODE) && ctl_valid) begin
        code_q   <= ALUCtl_code;
        offset_q <= br_address;
      end
      if ((state == ST_EXEC) && exec_done) begin
        pc <= next_pc;
        if (is_link) begin
          rf_link_data <= link_value;
        end
      end
      if (retire) begin
        retire_count <= retire_count + 32'd1;
      end
      if ((state == ST_FETCH) && !imem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

endmodule
